// File: rtl/pool_window_gen.sv
// 2x2 stride-2 window former for the max-pool datapath.
// Ports: clk/rst, in_valid/in_ready/in_data, out_valid/out_ready, data_1..4, out_last.
module pool_window_gen #(
  parameter int DATA_W = 32,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data_1,
  output logic [DATA_W-1:0] data_2,
  output logic [DATA_W-1:0] data_3,
  output logic [DATA_W-1:0] data_4,
  output logic              out_last
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic [DATA_W-1:0] hold;
  logic [DATA_W-1:0] line_buf [IMG_W];

  logic accept;
  logic col_end;
  logic row_end;
  logic win;
  logic [CW-1:0] col_left;

  assign in_ready = !rst && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign col_end  = (col == CW'(IMG_W - 1));
  assign row_end  = (row == RW'(IMG_H - 1));
  // Odd row and odd column: bottom-right pixel completes a window.
  assign win      = accept && row[0] && col[0];
  assign col_left = col - CW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col_end) begin
        col <= '0;
        row <= row_end ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // Line buffer holds only the even row; no reset needed.
  always_ff @(posedge clk) begin
    if (accept && !row[0]) begin
      line_buf[col] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold <= '0;
    end else if (accept && row[0] && !col[0]) begin
      hold <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      data_1    <= '0;
      data_2    <= '0;
      data_3    <= '0;
      data_4    <= '0;
    end else if (win) begin
      out_valid <= 1'b1;
      out_last  <= row_end && col_end;
      data_1    <= line_buf[col_left];
      data_2    <= line_buf[col];
      data_3    <= hold;
      data_4    <= in_data;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pool_window_gen.sv
// Directed bench for pool_window_gen on a 4x4 frame.
// Expected windows come from a hand-written table.
module tb_pool_window_gen;

  typedef struct packed {
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] d3;
    logic [31:0] d4;
    logic        last;
  } win_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] data_1, data_2, data_3, data_4;
  logic        out_last;

  pool_window_gen #(
    .DATA_W(32),
    .IMG_W (4),
    .IMG_H (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .data_1   (data_1),
    .data_2   (data_2),
    .data_3   (data_3),
    .data_4   (data_4),
    .out_last (out_last)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  win_t tbl [8];
  win_t q [$];
  int   wq [$];
  int   acc [16];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      q.push_back({data_1, data_2, data_3, data_4, out_last});
      wq.push_back(cyc);
    end
  end

  task automatic chk(input string nm, input logic [128:0] act,
                     input logic [128:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic send_px(input logic [31:0] v, input bit gaps,
                         input int idx);
    int n;
    bit ok;
    if (gaps) begin
      n = 0;
      while ($urandom_range(0, 1) == 1 && n < 6) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        n++;
      end
    end
    in_data  = v;
    in_valid = 1'b1;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = in_ready;
      if (ok) acc[idx] = cyc;
      @(posedge clk);
      #1;
      n++;
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL px_timeout: pixel %0d not accepted, want accept", v);
    end
  endtask

  task automatic send_frame(input int base, input bit gaps);
    for (int i = 0; i < 16; i++) send_px(32'(base + i), gaps, i);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    repeat (4) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_windows(input string nm, input int n);
    chk({nm, "_count"}, 129'(q.size()), 129'(n));
    for (int k = 0; k < n; k++) begin
      if (k < q.size())
        chk($sformatf("%s_win%0d", nm, k), q[k], tbl[k]);
    end
  endtask

  task automatic stall_ctrl();
    int n;
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("stall_hold", {data_1, data_2, data_3, data_4, out_last},
          {32'd0, 32'd1, 32'd4, 32'd5, 1'b0});
      chk("stall_valid", 129'(out_valid), 129'(1));
      chk("stall_in_ready", 129'(in_ready), 129'(0));
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
  endtask

  initial begin
    int br [4];
    tbl[0] = {32'd0,   32'd1,   32'd4,   32'd5,   1'b0};
    tbl[1] = {32'd2,   32'd3,   32'd6,   32'd7,   1'b0};
    tbl[2] = {32'd8,   32'd9,   32'd12,  32'd13,  1'b0};
    tbl[3] = {32'd10,  32'd11,  32'd14,  32'd15,  1'b1};
    tbl[4] = {32'd100, 32'd101, 32'd104, 32'd105, 1'b0};
    tbl[5] = {32'd102, 32'd103, 32'd106, 32'd107, 1'b0};
    tbl[6] = {32'd108, 32'd109, 32'd112, 32'd113, 1'b0};
    tbl[7] = {32'd110, 32'd111, 32'd114, 32'd115, 1'b1};
    br = '{5, 7, 13, 15};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;

    // Reset state
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("rst_outs", {data_1, data_2, data_3, data_4, out_last},
          129'(0));
      chk("rst_valid", 129'(out_valid), 129'(0));
      chk("rst_in_ready", 129'(in_ready), 129'(0));
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 129'(in_ready), 129'(1));
    @(posedge clk);
    #1;

    // Back-to-back frame with latency check
    q.delete();
    wq.delete();
    send_frame(0, 1'b0);
    drain();
    check_windows("s2", 4);
    for (int k = 0; k < 4; k++) begin
      if (k < wq.size())
        chk($sformatf("s2_lat%0d", k), 129'(wq[k]),
            129'(acc[br[k]] + 1));
    end

    // Downstream stall after first window
    q.delete();
    fork
      send_frame(0, 1'b0);
      stall_ctrl();
    join
    drain();
    check_windows("s3", 4);

    // Two frames back-to-back
    q.delete();
    send_frame(0, 1'b0);
    send_frame(100, 1'b0);
    drain();
    check_windows("s4", 8);

    // Random input gaps
    q.delete();
    send_frame(0, 1'b1);
    drain();
    check_windows("s5", 4);

    // Reset mid-frame after pixel 6
    for (int i = 0; i < 7; i++) send_px(32'(200 + i), 1'b0, i);
    in_valid = 1'b0;
    rst = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("s6_rst_valid", 129'(out_valid), 129'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    send_frame(0, 1'b0);
    drain();
    check_windows("s6", 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pool_window_gen.md
Name: pool_window_gen

Overview:
- Streaming front end for the 2x2 max-pool datapath.
- Accepts a raster-scan feature map one pixel per cycle and forms non-overlapping 2x2 windows (stride 2).
- Presents each window as four parallel words on data_1..data_4, the exact four-operand interface the pooling comparator consumes.
- Buffers one even row internally, so the pooling stage needs no memory of its own.

Parameters:
- DATA_W, 32: pixel width in bits.
- IMG_W, 8: pixels per row; must be even and at least 2.
- IMG_H, 8: rows per frame; must be even and at least 2.

Ports:
- Clock  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high reset.
- in_valid  in  1  in_data holds a pixel.
- in_ready  out  1  block accepts a pixel this cycle.
- in_data  in  DATA_W  pixel value in raster order.
- out_valid  out  1  window registers hold a valid window.
- out_ready  in  1  downstream accepts the window.
- data_1  out  DATA_W  top-left pixel (r-1, c-1).
- data_2  out  DATA_W  top-right pixel (r-1, c).
- data_3  out  DATA_W  bottom-left pixel (r, c-1).
- data_4  out  DATA_W  bottom-right pixel (r, c).
- out_last  out  1  current window is the last window of the frame.

Behaviour:
- Clocking and reset:
  - One clock. Reset is synchronous and active-high, sampled on the rising edge of Clock.
  - On reset: out_valid=0, out_last=0, data_1..data_4=0, col=0, row=0, bottom-left hold register=0.
  - Line-buffer contents are don't-care after reset.
  - in_ready=0 while Reset is high.
- Handshake:
  - A pixel is accepted when in_valid && in_ready.
  - A window is consumed when out_valid && out_ready.
  - in_ready = !out_valid || out_ready. This is a combinational pass-through and sustains 1 pixel/cycle with no bubbles.
- Counters:
  - col runs 0..IMG_W-1 and row runs 0..IMG_H-1. Both advance only on an accepted pixel.
  - When col reaches IMG_W-1, it wraps to 0 and row increments.
  - When row reaches IMG_H-1 and col reaches IMG_W-1, both wrap to 0; the next frame starts with no idle cycle.
- Even rows (row[0]=0):
  - Accepted pixel is written to line_buf[col] (IMG_W x DATA_W).
  - No output is produced.
- Odd rows, even col:
  - Pixel is stored in the bottom-left hold register.
  - No output is produced.
- Odd rows, odd col:
  - Window is complete. On the same edge: data_1=line_buf[col-1], data_2=line_buf[col], data_3=hold, data_4=in_data, out_valid=1.
  - Latency is 1 cycle from acceptance of the bottom-right pixel to out_valid.
  - out_last=1 iff row=IMG_H-1 and col=IMG_W-1; otherwise 0.
- Output hold and clear:
  - While out_valid && !out_ready, data_1..data_4 and out_last hold stable and in_ready=0.
  - out_valid clears on consumption unless a new window loads on the same edge; in that case out_valid stays 1 with the new data.
- Window count: exactly (IMG_W/2)*(IMG_H/2) windows per frame, in raster order of window position.
- Reset mid-frame: discards the partial frame and any pending window. The next accepted pixel is treated as (0,0).
- in_valid low: counters and buffer are frozen. Gaps in input are permitted anywhere in the frame.

Test Plan:
1. Reset: hold Reset 2 cycles → out_valid=0, out_last=0, data_1..4=0, in_ready=0 during reset, in_ready=1 after.
2. IMG_W=4, IMG_H=4, pixels 0..15 streamed back-to-back, out_ready=1 → windows (0,1,4,5), (2,3,6,7), (8,9,12,13), (10,11,14,15). Each appears 1 cycle after pixels 5, 7, 13, 15 are accepted. out_last=1 only on the 4th window.
3. Same stream with out_ready held low for 3 cycles after the first window → data_1..4 hold (0,1,4,5), in_ready=0 and no pixel is lost. Remaining windows are identical to scenario 2.
4. Two frames back-to-back (pixels 0..15, then 100..115) → the 8 windows are correct. The second frame starts with (100,101,104,105); out_last pulses twice.
5. in_valid toggled randomly 50% over scenario 2's stream → identical window sequence and values.
6. Reset asserted after pixel 6 is accepted, then a full frame 0..15 → no stale window is emitted; output exactly matches scenario 2.
